addsub_pipe: RTL and testbench

- Pipelined, flow-controlled successor to the combinational significand adder-subtractor.
- Computes in1+in2 or |in1-in2| with carry and subtraction-sign flags, for FP add/sub datapaths.
- Fixed 3-stage latency with valid/ready backpressure, synchronous flush and a sideband tag.
- Sits between exponent-align and normalize stages of fp_addsub.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_lzc.sv | 23 ++
 rtl/addsub_pipe.sv | 136 +++++++++++++
 tb/tb_addsub_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined significand adder-subtractor.
package addsub_pkg;

    localparam int ADDSUB_LAT = 3;

    localparam logic EOP_ADD = 1'b0;
    localparam logic EOP_SUB = 1'b1;

    function automatic int lzc_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/addsub_lzc.sv
// Combinational leading-zero counter; returns WIDTH for an all-zero input.
module addsub_lzc
    import addsub_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]        d,
    output logic [lzc_w(WIDTH)-1:0] cnt
);

    localparam int LW = lzc_w(WIDTH);

    // Scanning upward lets the highest set bit win the priority.
    always_comb begin
        cnt = LW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                cnt = LW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Three-stage valid/ready significand adder-subtractor with flush and sideband tag.
// Optional leading-zero count of the result is enabled by defining ADDSUB_PIPE_LZC_EN.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in1,
    input  logic [WIDTH-1:0]        in2,
    input  logic                    eop,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        res,
    output logic                    carry,
    output logic                    sign_sub,
    output logic [TAG_W-1:0]        out_tag,
    output logic [lzc_w(WIDTH)-1:0] lzc
);

    logic             v1_reg, v2_reg, v3_reg;
    logic             ld1, ld2, ld3;

    logic [WIDTH-1:0] a1_reg, b1_reg;
    logic             sub1_reg, neg1_reg;
    logic [TAG_W-1:0] tag1_reg;

    logic [WIDTH:0]   sum2_reg;
    logic             sub2_reg, neg2_reg;
    logic [TAG_W-1:0] tag2_reg;

    logic [WIDTH-1:0] res_reg, res_next;
    logic             carry_reg, neg3_reg;
    logic [TAG_W-1:0] tag3_reg;

    // Load chain: a stage may take new data when empty or when its successor drains it.
    assign ld3      = !v3_reg || out_ready;
    assign ld2      = !v2_reg || ld3;
    assign ld1      = !v1_reg || ld2;
    assign in_ready = ld1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else if (flush) begin
            v1_reg <= 1'b0;
            v2_reg <= 1'b0;
            v3_reg <= 1'b0;
        end else begin
            if (ld1) v1_reg <= in_valid;
            if (ld2) v2_reg <= v1_reg;
            if (ld3) v3_reg <= v2_reg;
        end
    end

    // Subtraction adds the two's complement of in2; its magnitude is fixed up in S3.
    assign res_next = (sub2_reg && neg2_reg) ? -sum2_reg[WIDTH-1:0] : sum2_reg[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1_reg    <= '0;
            b1_reg    <= '0;
            sub1_reg  <= 1'b0;
            neg1_reg  <= 1'b0;
            tag1_reg  <= '0;
            sum2_reg  <= '0;
            sub2_reg  <= 1'b0;
            neg2_reg  <= 1'b0;
            tag2_reg  <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            neg3_reg  <= 1'b0;
            tag3_reg  <= '0;
        end else begin
            if (ld1) begin
                a1_reg   <= in1;
                b1_reg   <= (eop == EOP_SUB) ? -in2 : in2;
                sub1_reg <= (eop == EOP_SUB);
                neg1_reg <= (in2 > in1);
                tag1_reg <= in_tag;
            end
            if (ld2) begin
                sum2_reg <= {1'b0, a1_reg} + {1'b0, b1_reg};
                sub2_reg <= sub1_reg;
                neg2_reg <= neg1_reg;
                tag2_reg <= tag1_reg;
            end
            if (ld3) begin
                res_reg   <= res_next;
                carry_reg <= sum2_reg[WIDTH];
                neg3_reg  <= neg2_reg;
                tag3_reg  <= tag2_reg;
            end
        end
    end

`ifdef ADDSUB_PIPE_LZC_EN
    localparam int LW = lzc_w(WIDTH);

    logic [LW-1:0] lzc_next, lzc_reg;

    addsub_lzc #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .d   (res_next),
        .cnt (lzc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lzc_reg <= '0;
        end else if (ld3) begin
            lzc_reg <= lzc_next;
        end
    end

    assign lzc = lzc_reg;
`else
    assign lzc = '0;
`endif

    assign out_valid = v3_reg;
    assign res       = res_reg;
    assign carry     = carry_reg;
    assign sign_sub  = neg3_reg;
    assign out_tag   = tag3_reg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: random and directed beats against an arithmetic reference model.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int LW = $clog2(W + 1);
`ifdef ADDSUB_PIPE_LZC_EN
    localparam bit LZC_ON = 1'b1;
`else
    localparam bit LZC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, eop;
    logic [W-1:0]  in1, in2, res;
    logic [TW-1:0] in_tag, out_tag;
    logic          out_valid, out_ready, carry, sign_sub;
    logic [LW-1:0] lzc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0]  res;
        logic          c;
        logic          s;
        logic [TW-1:0] tag;
        logic [LW-1:0] lz;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .eop       (eop),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .sign_sub  (sign_sub),
        .out_tag   (out_tag),
        .lzc       (lzc)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lz_of(input int v);
        int n = W;
        while (v > 0) begin
            v = v >> 1;
            n--;
        end
        return n;
    endfunction

    // Reference: plain sum for add, absolute difference for subtract.
    function automatic exp_t model(input int a, input int b, input logic e, input logic [TW-1:0] t);
        exp_t x;
        int   r;
        x.s = (b > a);
        if (e == EOP_ADD) begin
            r   = (a + b) % (1 << W);
            x.c = ((a + b) >= (1 << W));
        end else begin
            r   = (a >= b) ? (a - b) : (b - a);
            x.c = (b != 0) && (a >= b);
        end
        x.res = W'(r);
        x.tag = t;
        x.lz  = LZC_ON ? LW'(lz_of(r)) : '0;
        return x;
    endfunction

    // Acceptance logger: beats that cross the input handshake at the coming edge.
    always @(negedge clk) begin
        #1;
        if (rst || flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back(model(int'(in1), int'(in2), eop, in_tag));
        end
    end

    // Output monitor: backpressure invariant, stall stability and in-order result checks.
    logic          hold_prev = 1'b0;
    logic [W-1:0]  h_res;
    logic          h_c, h_s;
    logic [TW-1:0] h_tag;
    logic [LW-1:0] h_lz;

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_in_reset", {31'd0, in_ready}, 32'd1);
            hold_prev = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (out_ready || q.size() < ADDSUB_LAT)});
            if (hold_prev) begin
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_res", {24'd0, res}, {24'd0, h_res});
                check("stall_tag", {28'd0, out_tag}, {28'd0, h_tag});
                check("stall_flags", {30'd0, carry, sign_sub}, {30'd0, h_c, h_s});
                check("stall_lzc", {28'd0, lzc}, {28'd0, h_lz});
            end
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_result: got tag %0d expected no result", out_tag);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("res", {24'd0, res}, {24'd0, e.res});
                    check("carry", {31'd0, carry}, {31'd0, e.c});
                    check("sign_sub", {31'd0, sign_sub}, {31'd0, e.s});
                    check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
                    check("lzc", {28'd0, lzc}, {28'd0, e.lz});
                    $display("tx tag=%0d res=%0d carry=%0b sign_sub=%0b lzc=%0d",
                             out_tag, res, carry, sign_sub, lzc);
                end
            end
            hold_prev = out_valid && !out_ready && !flush;
            h_res = res;
            h_c   = carry;
            h_s   = sign_sub;
            h_tag = out_tag;
            h_lz  = lzc;
        end
    end

    // Drives one beat into an empty pipe and checks it emerges exactly three edges later.
    task automatic dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic e,
                       input logic [TW-1:0] t, input int er, input int ec, input int es,
                       input int el);
        out_ready = 1'b1;
        in1 = a; in2 = b; eop = e; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        check("dir_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("dir_lat_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("dir_lat_valid", {31'd0, out_valid}, 32'd1);
        check("dir_res", {24'd0, res}, er);
        check("dir_carry", {31'd0, carry}, ec);
        check("dir_sign_sub", {31'd0, sign_sub}, es);
        check("dir_tag", {28'd0, out_tag}, {28'd0, t});
        check("dir_lzc", {28'd0, lzc}, LZC_ON ? el : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic e,
                        input logic [TW-1:0] t);
        bit ok = 1'b0;
        in1 = a; in2 = b; eop = e; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 6)
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom % 4);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drain(input string nm);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(nm, q.size(), 0);
    endtask

    initial begin
        bit saw_block;
        int sent;
        bit got;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; eop = EOP_ADD; in_tag = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_res", {24'd0, res}, 32'd0);
        check("rst_flags", {30'd0, carry, sign_sub}, 32'd0);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check("rst_lzc", {28'd0, lzc}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        dir(8'd5,   8'd3,   EOP_SUB, 4'd1, 2,  1, 0, 6);
        dir(8'd3,   8'd5,   EOP_SUB, 4'd2, 2,  0, 1, 6);
        dir(8'd7,   8'd0,   EOP_SUB, 4'd3, 7,  0, 0, 5);
        dir(8'd200, 8'd100, EOP_ADD, 4'd4, 44, 1, 0, 2);
        dir(8'd0,   8'd0,   EOP_ADD, 4'd5, 0,  0, 0, 8);
        dir(8'd255, 8'd1,   EOP_ADD, 4'd6, 0,  1, 0, 8);
        dir(8'd9,   8'd9,   EOP_SUB, 4'd7, 0,  1, 0, 8);

        // Back-to-back tags 1..6 with a four-cycle output stall mid-stream.
        saw_block = 1'b0;
        sent = 0;
        for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
            out_ready = !(c >= 3 && c < 7);
            if (sent < 6) begin
                in_valid = 1'b1;
                in1 = rnd_op(); in2 = rnd_op(); eop = $urandom % 2 == 1;
                in_tag = TW'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (in_valid && !in_ready) saw_block = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stall_backpressure_seen", {31'd0, saw_block}, 32'd1);
        check("stall_all_sent", sent, 6);
        drain("stall_drain");

        // Flush with three beats in flight and a fourth beat presented.
        out_ready = 1'b1;
        send(8'd10, 8'd1, EOP_ADD, 4'd10);
        send(8'd20, 8'd2, EOP_ADD, 4'd11);
        send(8'd30, 8'd3, EOP_SUB, 4'd12);
        in1 = 8'd40; in2 = 8'd4; eop = EOP_ADD; in_tag = 4'd13;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        dir(8'd50, 8'd60, EOP_SUB, 4'd14, 10, 0, 1, 4);

        // Asynchronous reset while a result is being held.
        out_ready = 1'b0;
        send(8'd10, 8'd20, EOP_ADD, 4'd8);
        send(8'd90, 8'd20, EOP_ADD, 4'd9);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        check("pre_rst_out_valid", {31'd0, got}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_res", {24'd0, res}, 32'd0);
        check("async_rst_out_tag", {28'd0, out_tag}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        dir(8'd128, 8'd128, EOP_ADD, 4'd15, 0, 1, 0, 8);

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 500; c++) begin
            out_ready = ($urandom % 4) != 0;
            in_valid  = ($urandom % 4) != 0;
            in1 = rnd_op();
            in2 = ($urandom % 8 == 0) ? in1 : rnd_op();
            eop = ($urandom % 2) == 1;
            in_tag = TW'($urandom);
            @(posedge clk);
            #1;
        end
        drain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
